// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-channel arbiter onto the MIG app interface with in-order read-return routing
module mem_req_arbiter #(
  parameter int N_CH      = 3,
  parameter int AW        = 29,
  parameter int DW        = 128,
  parameter int PRIO_MODE = 0,
  parameter int MAX_OUT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req_valid,
  output logic [N_CH-1:0]        req_ready,
  input  logic [N_CH-1:0]        req_we,
  input  logic [N_CH*AW-1:0]     req_addr,
  input  logic [N_CH*DW-1:0]     req_wdata,
  input  logic [N_CH*DW/8-1:0]   req_wmask,
  output logic [N_CH-1:0]        rsp_valid,
  output logic [DW-1:0]          rsp_data,
  output logic [AW-1:0]          app_addr,
  output logic [2:0]             app_cmd,
  output logic                   app_en,
  input  logic                   app_rdy,
  output logic [DW-1:0]          app_wdf_data,
  output logic [DW/8-1:0]        app_wdf_mask,
  output logic                   app_wdf_wren,
  output logic                   app_wdf_end,
  input  logic                   app_wdf_rdy,
  input  logic [DW-1:0]          app_rd_data,
  input  logic                   app_rd_data_valid,
  output logic                   err_orphan
);
  localparam int IW = $clog2(N_CH);
  localparam int PW = $clog2(MAX_OUT);
  localparam int MW = DW / 8;
  localparam logic [PW:0] MAXC = MAX_OUT[PW:0];
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t st, st_n;
  logic [IW-1:0] id, ptr, win;
  logic [IW-1:0] fifo [MAX_OUT];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [MW-1:0] wmask_r;
  logic [N_CH-1:0] elig;
  logic found, acc, push, pop;
  always_comb begin
    elig = req_valid & (req_we | {N_CH{cnt < MAXC}});
    win = '0;
    found = 1'b0;
    if (PRIO_MODE != 0) begin
      for (int i = N_CH - 1; i >= 0; i--)
        if (elig[i]) win = IW'(i);
    end else begin
      for (int k = 1; k <= N_CH; k++)
        if (!found && elig[(int'(ptr) + k) % N_CH]) begin
          win = IW'((int'(ptr) + k) % N_CH);
          found = 1'b1;
        end
    end
  end
  assign acc  = (st == ISSUE) && app_rdy && (!we_r || app_wdf_rdy);
  assign push = acc && !we_r;
  assign pop  = app_rd_data_valid && (cnt != '0);
  always_ff @(posedge clk) st <= !rst ? IDLE : st_n;
  always_comb st_n = (st == IDLE) ? ((|elig) ? ISSUE : IDLE) : (acc ? IDLE : ISSUE);
  always_comb begin
    app_en       = (st == ISSUE);
    app_wdf_wren = app_en & we_r;
    app_wdf_end  = app_wdf_wren;
    app_cmd      = {2'b00, app_en & ~we_r};
    app_addr     = addr_r;
    app_wdf_data = wdata_r;
    app_wdf_mask = wmask_r;
    req_ready    = acc ? (N_CH'(1) << id) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      id         <= '0;
      ptr        <= IW'(N_CH - 1);
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      wmask_r    <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (st == IDLE && |elig) begin
        id      <= win;
        we_r    <= req_we[win];
        addr_r  <= req_addr[win*AW +: AW];
        wdata_r <= req_wdata[win*DW +: DW];
        wmask_r <= req_wmask[win*MW +: MW];
      end
      if (acc) ptr <= id;
      if (push) begin
        fifo[wp] <= id;
        wp       <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt       <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      rsp_valid <= pop ? (N_CH'(1) << fifo[rp]) : '0;
      if (pop) rsp_data <= app_rd_data;
      if (app_rd_data_valid && cnt == '0) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed checks of a round-robin instance (a) and a fixed-priority, 2-deep instance (b)
module tb_mem_req_arbiter;
  localparam int N = 3, AW = 29, DW = 32, MW = 4;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_wmask;
  logic app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [DW-1:0] app_rd_data;
  logic [N-1:0] req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
  logic [DW-1:0] rsp_data_a, wdf_data_a, rsp_data_b, wdf_data_b;
  logic [AW-1:0] app_addr_a, app_addr_b;
  logic [2:0] app_cmd_a, app_cmd_b;
  logic [MW-1:0] wdf_mask_a, wdf_mask_b;
  logic app_en_a, wren_a, wend_a, orph_a, app_en_b, wren_b, wend_b, orph_b;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .PRIO_MODE(0), .MAX_OUT(8)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .app_addr(app_addr_a), .app_cmd(app_cmd_a),
    .app_en(app_en_a), .app_rdy(app_rdy), .app_wdf_data(wdf_data_a), .app_wdf_mask(wdf_mask_a),
    .app_wdf_wren(wren_a), .app_wdf_end(wend_a), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .err_orphan(orph_a));

  mem_req_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .PRIO_MODE(1), .MAX_OUT(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .app_addr(app_addr_b), .app_cmd(app_cmd_b),
    .app_en(app_en_b), .app_rdy(app_rdy), .app_wdf_data(wdf_data_b), .app_wdf_mask(wdf_mask_b),
    .app_wdf_wren(wren_b), .app_wdf_end(wend_b), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .err_orphan(orph_b));

  task automatic clear_inputs;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 0; clear_inputs; tick; tick; rst = 1;
  endtask

  task automatic test_reset;
    rst = 0; clear_inputs; tick; tick;
    n_chk++; if ({app_en_a, wren_a, wend_a, orph_a} !== 4'b0) begin n_fail++; $display("FAIL rst_ctl_a: got %b exp 0000", {app_en_a, wren_a, wend_a, orph_a}); end
    n_chk++; if ({app_cmd_a, app_addr_a} !== '0) begin n_fail++; $display("FAIL rst_cmd_addr_a: got %h exp 0", {app_cmd_a, app_addr_a}); end
    n_chk++; if ({req_ready_a, rsp_valid_a, rsp_data_a, wdf_data_a, wdf_mask_a} !== '0) begin n_fail++; $display("FAIL rst_data_a: got %h exp 0", {req_ready_a, rsp_valid_a, rsp_data_a, wdf_data_a, wdf_mask_a}); end
    n_chk++; if ({app_en_b, wren_b, wend_b, orph_b, app_cmd_b, req_ready_b, rsp_valid_b, rsp_data_b} !== '0) begin n_fail++; $display("FAIL rst_b: got %h exp 0", {app_en_b, wren_b, wend_b, orph_b, app_cmd_b, req_ready_b, rsp_valid_b, rsp_data_b}); end
    rst = 1;
  endtask

  task automatic test_single_write;
    req_valid = 3'b010; req_we = 3'b010;
    req_addr[1*AW +: AW] = 29'h100; req_wdata[1*DW +: DW] = 32'hA5A5A5A5; req_wmask = '0;
    app_rdy = 1; app_wdf_rdy = 1; #1;
    n_chk++; if (app_en_a !== 1'b0) begin n_fail++; $display("FAIL t1_en_c0: got %b exp 0", app_en_a); end
    tick;
    n_chk++; if ({app_en_a, wren_a, wend_a} !== 3'b111) begin n_fail++; $display("FAIL t1_en_wren: got %b exp 111", {app_en_a, wren_a, wend_a}); end
    n_chk++; if (req_ready_a !== 3'b010) begin n_fail++; $display("FAIL t1_ready: got %b exp 010", req_ready_a); end
    n_chk++; if (app_cmd_a !== 3'b000) begin n_fail++; $display("FAIL t1_cmd: got %h exp 0", app_cmd_a); end
    n_chk++; if ({app_addr_a, wdf_data_a} !== {29'h100, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL t1_addr_data: got %h/%h exp 100/a5a5a5a5", app_addr_a, wdf_data_a); end
    req_valid = '0; tick;
    n_chk++; if ({app_en_a, wren_a, req_ready_a} !== 5'b0) begin n_fail++; $display("FAIL t1_drop: got %b exp 0", {app_en_a, wren_a, req_ready_a}); end
  endtask

  task automatic test_rr_reads;
    do_reset;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(32'h10 + i);
    req_valid = 3'b111; req_we = 3'b000; app_rdy = 1; app_wdf_rdy = 1;
    for (int g = 0; g < 6; g++) begin
      tick;
      n_chk++; if (req_ready_a !== 3'(1 << (g % 3))) begin n_fail++; $display("FAIL t2_grant%0d: got %b exp %b", g, req_ready_a, 3'(1 << (g % 3))); end
      n_chk++; if ({app_cmd_a, app_addr_a} !== {3'b001, AW'(32'h10 + g % 3)}) begin n_fail++; $display("FAIL t2_cmd_addr%0d: got %h/%h exp 1/%h", g, app_cmd_a, app_addr_a, 32'h10 + g % 3); end
      tick;
      n_chk++; if (app_en_a !== 1'b0) begin n_fail++; $display("FAIL t2_gap%0d: got %b exp 0", g, app_en_a); end
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      app_rd_data_valid = 1; app_rd_data = 32'hD0000000 + k;
      tick;
      n_chk++; if (rsp_valid_a !== 3'(1 << (k % 3))) begin n_fail++; $display("FAIL t2_rsp%0d: got %b exp %b", k, rsp_valid_a, 3'(1 << (k % 3))); end
      n_chk++; if (rsp_data_a !== 32'hD0000000 + k) begin n_fail++; $display("FAIL t2_rdata%0d: got %h exp %h", k, rsp_data_a, 32'hD0000000 + k); end
    end
    app_rd_data_valid = 0; app_rd_data = 32'h0BADF00D; tick;
    n_chk++; if ({rsp_valid_a, orph_a} !== 4'b0) begin n_fail++; $display("FAIL t2_idle: got %b exp 0", {rsp_valid_a, orph_a}); end
    n_chk++; if (rsp_data_a !== 32'hD0000005) begin n_fail++; $display("FAIL t2_hold: got %h exp d0000005", rsp_data_a); end
  endtask

  task automatic test_wdf_stall;
    req_valid = 3'b001; req_we = 3'b001;
    req_addr[0 +: AW] = 29'h200; req_wdata[0 +: DW] = 32'h12345678; req_wmask[0 +: MW] = 4'b0101;
    app_rdy = 1; app_wdf_rdy = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if ({app_en_a, wren_a, wend_a, app_cmd_a} !== 6'b111000) begin n_fail++; $display("FAIL t3_ctl%0d: got %b exp 111000", i, {app_en_a, wren_a, wend_a, app_cmd_a}); end
      n_chk++; if ({app_addr_a, wdf_data_a, wdf_mask_a} !== {29'h200, 32'h12345678, 4'b0101}) begin n_fail++; $display("FAIL t3_hold%0d: got %h/%h/%b exp 200/12345678/0101", i, app_addr_a, wdf_data_a, wdf_mask_a); end
      n_chk++; if (req_ready_a !== 3'b000) begin n_fail++; $display("FAIL t3_noready%0d: got %b exp 000", i, req_ready_a); end
      if (i < 4) tick;
    end
    tick;
    app_wdf_rdy = 1; #1;
    n_chk++; if (req_ready_a !== 3'b001) begin n_fail++; $display("FAIL t3_accept: got %b exp 001", req_ready_a); end
    req_valid = '0; tick;
    n_chk++; if (app_en_a !== 1'b0) begin n_fail++; $display("FAIL t3_done: got %b exp 0", app_en_a); end
  endtask

  task automatic test_orphan_and_reset;
    app_rd_data_valid = 1; app_rd_data = 32'hDEADBEEF; tick;
    n_chk++; if (orph_a !== 1'b1) begin n_fail++; $display("FAIL t6_orphan: got %b exp 1", orph_a); end
    n_chk++; if (rsp_valid_a !== 3'b000) begin n_fail++; $display("FAIL t6_norsp: got %b exp 000", rsp_valid_a); end
    n_chk++; if (rsp_data_a !== 32'hD0000005) begin n_fail++; $display("FAIL t6_rdata_hold: got %h exp d0000005", rsp_data_a); end
    app_rd_data_valid = 0; tick;
    n_chk++; if (orph_a !== 1'b1) begin n_fail++; $display("FAIL t6_sticky: got %b exp 1", orph_a); end
    req_valid = 3'b010; req_we = 3'b000; req_addr[1*AW +: AW] = 29'h1ABC; app_rdy = 0; tick;
    n_chk++; if ({app_en_a, app_cmd_a, app_addr_a} !== {1'b1, 3'b001, 29'h1ABC}) begin n_fail++; $display("FAIL t6_issue: got %h exp 1/1/1abc", {app_en_a, app_cmd_a, app_addr_a}); end
    rst = 0; tick;
    n_chk++; if ({app_en_a, wren_a, app_cmd_a, app_addr_a, req_ready_a, orph_a, rsp_data_a} !== '0) begin n_fail++; $display("FAIL t6_midreset: got %h exp 0", {app_en_a, wren_a, app_cmd_a, app_addr_a, req_ready_a, orph_a, rsp_data_a}); end
    rst = 1; clear_inputs;
  endtask

  task automatic test_max_out;
    do_reset;
    req_valid = 3'b101; req_we = 3'b100; app_rdy = 1; app_wdf_rdy = 1;
    for (int r = 0; r < 2; r++) begin
      tick;
      n_chk++; if ({req_ready_b, app_cmd_b} !== {3'b001, 3'b001}) begin n_fail++; $display("FAIL t4_read%0d: got %b/%h exp 001/1", r, req_ready_b, app_cmd_b); end
      tick;
    end
    tick;
    n_chk++; if ({req_ready_b, app_cmd_b, wren_b} !== {3'b100, 3'b000, 1'b1}) begin n_fail++; $display("FAIL t4_write: got %b/%h/%b exp 100/0/1", req_ready_b, app_cmd_b, wren_b); end
    req_valid = 3'b001; tick; tick;
    n_chk++; if (app_en_b !== 1'b0) begin n_fail++; $display("FAIL t4_stall: got %b exp 0", app_en_b); end
    app_rd_data_valid = 1; app_rd_data = 32'h0000BEEF; tick;
    n_chk++; if ({app_en_b, rsp_valid_b, rsp_data_b} !== {1'b0, 3'b001, 32'h0000BEEF}) begin n_fail++; $display("FAIL t4_return: got %b/%b/%h exp 0/001/beef", app_en_b, rsp_valid_b, rsp_data_b); end
    app_rd_data_valid = 0; tick;
    n_chk++; if ({app_en_b, req_ready_b, app_cmd_b} !== {1'b1, 3'b001, 3'b001}) begin n_fail++; $display("FAIL t4_third: got %b/%b/%h exp 1/001/1", app_en_b, req_ready_b, app_cmd_b); end
    req_valid = '0; tick;
  endtask

  task automatic test_fixed_prio;
    logic [N-1:0] exp_a [4];
    exp_a[0] = 3'b001; exp_a[1] = 3'b100; exp_a[2] = 3'b001; exp_a[3] = 3'b100;
    do_reset;
    req_valid = 3'b101; req_we = 3'b101; app_rdy = 1; app_wdf_rdy = 1;
    for (int g = 0; g < 4; g++) begin
      tick;
      n_chk++; if (req_ready_b !== (g < 3 ? 3'b001 : 3'b100)) begin n_fail++; $display("FAIL t5_fixed%0d: got %b exp %b", g, req_ready_b, (g < 3 ? 3'b001 : 3'b100)); end
      n_chk++; if (req_ready_a !== exp_a[g]) begin n_fail++; $display("FAIL t5_rr%0d: got %b exp %b", g, req_ready_a, exp_a[g]); end
      if (g == 2) req_valid = 3'b100;
      tick;
    end
    req_valid = '0;
  endtask

  initial begin
    clear_inputs;
    test_reset;
    test_single_write;
    test_rr_reads;
    test_wdf_stall;
    test_orphan_and_reset;
    test_max_out;
    test_fixed_prio;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
